// File: rtl/zap_wb_pkg.sv
// Shared Wishbone cycle-type codes and responder FSM states.
// No logic; imported by the slave and its testbench.
package zap_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    BURST = 2'd3
  } wb_state_e;

endpackage

// File: rtl/zap_wb_burst_slave_if.sv
// Wishbone B3 bus bundle between a master and the burst responder.
// Names keep the responder's i_/o_ view so both modports read naturally.
interface zap_wb_if;

  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_wen;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [2:0]  i_wb_cti;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;
  logic        o_wb_err;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_adr, i_wb_dat, i_wb_cti,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_adr, i_wb_dat, i_wb_cti,
    output o_wb_dat, o_wb_ack, o_wb_err
  );

endinterface

// File: rtl/zap_wb_ram_array.sv
// Single-port DEPTH x 32 RAM with byte write enables; read data registered one edge
// after i_re, and the read register returns zero on any edge without i_re.
module zap_wb_ram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic          i_re,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdat,
  output logic [31:0]   o_rdat
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdat_d;
  logic [31:0] rdat_q;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) begin
        mem[i_idx][8*b +: 8] <= i_wdat[8*b +: 8];
      end
    end
  end

  // Clearing on non-read edges lets this register drive the bus data directly.
  always_comb begin
    rdat_d = '0;
    if (i_re) begin
      rdat_d = mem[i_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rdat_q <= '0;
    end else begin
      rdat_q <= rdat_d;
    end
  end

  assign o_rdat = rdat_q;

endmodule

// File: rtl/zap_wb_burst_slave.sv
// Wishbone B3 classic + incrementing-burst RAM responder; first beat acked WAIT_STATES+1
// cycles after the request, burst beats every cycle; stb low in a burst stalls without ack.
module zap_wb_burst_slave
  import zap_wb_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 2
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  zap_wb_if.slave  wb,
  output logic     o_busy
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  wb_state_e   state_d, state_q;
  logic [3:0]  cnt_d, cnt_q;
  logic [31:2] exp_d, exp_q;
  logic        burst_d, burst_q;
  logic        ack_d, ack_q;
  logic        err_d, err_q;
  logic        busy_d, busy_q;

  logic          req;
  logic          take;
  logic          chk_seq;
  logic [31:0]   off;
  logic          beat_ok;
  logic          we;
  logic          re;
  logic [AW-1:0] idx;
  logic [31:0]   rdat;

  assign req = wb.i_wb_cyc & wb.i_wb_stb;
  assign off = wb.i_wb_adr - BASE_ADDR;
  assign idx = off[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    burst_d = burst_q;
    take    = 1'b0;
    chk_seq = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          burst_d = (wb.i_wb_cti == CTI_INCR);
          if (WS == 4'd0) begin
            take    = 1'b1;
            state_d = ACK;
          end else begin
            cnt_d   = WS;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb.i_wb_cyc) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          if (wb.i_wb_stb) begin
            take    = 1'b1;
            cnt_d   = 4'd0;
            state_d = ACK;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        // The master already shows its next beat while the first ack is visible.
        if (!wb.i_wb_cyc || !burst_q) begin
          state_d = IDLE;
        end else begin
          state_d = BURST;
          if (wb.i_wb_stb) begin
            take    = 1'b1;
            chk_seq = 1'b1;
            if (wb.i_wb_cti != CTI_INCR) begin
              state_d = IDLE;
            end
          end
        end
      end
      BURST: begin
        if (!wb.i_wb_cyc) begin
          state_d = IDLE;
        end else if (wb.i_wb_stb) begin
          take    = 1'b1;
          chk_seq = 1'b1;
          if (wb.i_wb_cti != CTI_INCR) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Expected address tracks the burst regardless of what the master sent.
    if (take) begin
      exp_d = (chk_seq ? exp_q : wb.i_wb_adr[31:2]) + 30'd1;
    end

    beat_ok = ({1'b0, off} < SPAN) && (!chk_seq || (wb.i_wb_adr[31:2] == exp_q));
    ack_d   = take;
    err_d   = take & ~beat_ok;
    we      = take & beat_ok & wb.i_wb_wen;
    re      = take & beat_ok & ~wb.i_wb_wen;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      exp_q   <= '0;
      burst_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      burst_q <= burst_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  zap_wb_ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_we      (we),
    .i_be      (wb.i_wb_sel),
    .i_re      (re),
    .i_idx     (idx),
    .i_wdat    (wb.i_wb_dat),
    .o_rdat    (rdat)
  );

  assign wb.o_wb_dat = rdat;
  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_err = err_q;
  assign o_busy      = busy_q;

endmodule
